// File: rtl/light_step_ctrl.sv
// Run-control front end for the light sequencer.
// Three raw buttons are synchronised, debounced and turned into press pulses. These pulses
// drive a run/pause/stop FSM. The FSM produces the sequencer enable level and a
// programmable-rate step pulse. It also stops automatically after a programmed step count.
module light_step_ctrl #(
  parameter int unsigned DEBOUNCE = 500000,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_btn,
  input  logic                pause_btn,
  input  logic                stop_btn,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          max_steps,
  output logic                enable,
  output logic                step,
  output logic [1:0]          state,
  output logic [7:0]          step_count
);

  localparam int unsigned      CntW   = $clog2(DEBOUNCE);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  // ---------------------------------------------------------------------------
  // Button path: bit 0 = start, bit 1 = pause, bit 2 = stop
  // ---------------------------------------------------------------------------
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      db_q, db_d, db_dly_q;
  logic [2:0]      press_q;
  logic [CntW-1:0] db_cnt_q [3];
  logic [CntW-1:0] db_cnt_d [3];

  assign btn_raw = {stop_btn, pause_btn, start_btn};

  // Debounce: the level flips after DEBOUNCE consecutive samples that disagree with it
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == CntMax) begin
        db_d[i]     = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CntW'(1);
      end
    end
  end

  // Synchroniser, debounce state and registered press (rising-edge) pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      // Registered so the pulse lands one cycle after the debounced level rises
      press_q  <= db_q & ~db_dly_q;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  logic start_p, pause_p, stop_p;
  assign start_p = press_q[0];
  assign pause_p = press_q[1];
  assign stop_p  = press_q[2];

  // ---------------------------------------------------------------------------
  // Run/pause/stop FSM with prescaler and step counter
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [PERIOD_W-1:0]   pre_q, pre_d;
  logic [7:0]            cnt_q, cnt_d, cnt_inc;
  logic                  step_q, step_d;
  logic                  enable_q, enable_d;
  logic [PERIOD_W-1:0]   eff_last;
  logic                  wrap;

  // Period 0 behaves like period 1; >= lets a mid-run shrink wrap immediately
  assign eff_last = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign wrap     = (pre_q >= eff_last);
  assign cnt_inc  = cnt_q + 8'd1;

  // Next state, prescaler and counter; priority stop > start > pause
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        pre_d = '0;
        if (start_p) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (stop_p) begin
          state_d = StIdle;
          pre_d   = '0;
        end else if (pause_p) begin
          // Pause beats a due step; prescaler keeps its pre-wrap value
          state_d = StPause;
        end else if (wrap) begin
          pre_d  = '0;
          step_d = 1'b1;
          cnt_d  = cnt_inc;
          if ((max_steps != 8'd0) && (cnt_inc == max_steps)) state_d = StDone;
        end else begin
          pre_d = pre_q + PERIOD_W'(1);
        end
      end
      StPause: begin
        if (stop_p) begin
          state_d = StIdle;
          pre_d   = '0;
        end else if (start_p) begin
          state_d = StRun;
        end
      end
      StDone: begin
        if (stop_p) begin
          state_d = StIdle;
          pre_d   = '0;
        end else if (start_p) begin
          state_d = StRun;
          pre_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
    enable_d = (state_d == StRun) || (state_d == StPause);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pre_q    <= '0;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      enable_q <= enable_d;
    end
  end

  assign enable     = enable_q;
  assign step       = step_q;
  assign state      = state_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_light_step_ctrl.sv
// Bench for light_step_ctrl: constant vector table, hand sequences and random stimulus
// compared every cycle against a behavioural model.
module tb_light_step_ctrl;

  localparam int unsigned Deb = 4;
  localparam int unsigned PW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_btn, pause_btn, stop_btn;
  logic [PW-1:0] period;
  logic [7:0]    max_steps;
  logic          enable, step;
  logic [1:0]    state;
  logic [7:0]    step_count;

  always #5 clk = ~clk;

  light_step_ctrl #(.DEBOUNCE(Deb), .PERIOD_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .stop_btn   (stop_btn),
    .period     (period),
    .max_steps  (max_steps),
    .enable     (enable),
    .step       (step),
    .state      (state),
    .step_count (step_count)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Behavioural model ---------------------------------------------------------
  localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;
  int m_mode, m_pre, m_cnt;
  bit m_step;
  bit raw_p0 [3];
  bit raw_p1 [3];
  bit lvl    [3];
  bit rose_p0[3];
  bit rose_p1[3];
  bit hist   [3][Deb];
  int hist_n [3];

  task automatic model_clear();
    m_mode = MIdle; m_pre = 0; m_cnt = 0; m_step = 0;
    for (int b = 0; b < 3; b++) begin
      raw_p0[b] = 0; raw_p1[b] = 0; lvl[b] = 0; rose_p0[b] = 0; rose_p1[b] = 0;
      hist_n[b] = 0;
      for (int i = 0; i < Deb; i++) hist[b][i] = 0;
    end
  endtask

  // One rising edge of the model; inputs are the values the DUT samples on this edge
  task automatic model_edge();
    bit [2:0] raw;
    bit ev[3];
    bit s, all_diff;
    int eff;
    cyc++;
    if (reset) begin
      model_clear();
    end else begin
      raw = {stop_btn, pause_btn, start_btn};
      for (int b = 0; b < 3; b++) begin
        ev[b] = rose_p1[b];         // debounced rise two edges ago reaches the FSM now
        rose_p1[b] = rose_p0[b];
        s = raw_p1[b];              // raw value from two edges ago = synchronised value
        raw_p1[b] = raw_p0[b];
        raw_p0[b] = raw[b];
        for (int i = Deb - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = s;
        if (hist_n[b] < Deb) hist_n[b]++;
        all_diff = (hist_n[b] == Deb);
        for (int i = 0; i < Deb; i++) if (hist[b][i] == lvl[b]) all_diff = 0;
        rose_p0[b] = 0;
        if (all_diff) begin
          lvl[b] = s;
          hist_n[b] = 0;
          rose_p0[b] = s;
        end
      end
      m_step = 0;
      eff = (period == 0) ? 1 : int'(period);
      case (m_mode)
        MIdle: begin
          m_pre = 0;
          if (ev[0]) begin m_mode = MRun; m_cnt = 0; end
        end
        MRun: begin
          if (ev[2]) begin m_mode = MIdle; m_pre = 0; end
          else if (ev[1]) m_mode = MPause;
          else if (m_pre >= eff - 1) begin
            m_pre = 0;
            m_step = 1;
            m_cnt = (m_cnt + 1) % 256;
            if (max_steps != 0 && m_cnt == int'(max_steps)) m_mode = MDone;
          end else m_pre++;
        end
        MPause: begin
          if (ev[2]) begin m_mode = MIdle; m_pre = 0; end
          else if (ev[0]) m_mode = MRun;
        end
        default: begin
          if (ev[2]) begin m_mode = MIdle; m_pre = 0; end
          else if (ev[0]) begin m_mode = MRun; m_pre = 0; m_cnt = 0; end
        end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic en,
                       input logic sp, input logic [7:0] cnt);
    checks++;
    if (state === st && enable === en && step === sp && step_count === cnt) passed++;
    else $display("FAIL %s cyc %0d: got state=%b en=%b step=%b cnt=%0d want state=%b en=%b step=%b cnt=%0d",
                  name, cyc, state, enable, step, step_count, st, en, sp, cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", 2'(m_mode), (m_mode == MRun) || (m_mode == MPause), m_step, 8'(m_cnt));
  endtask

  // Directed vector table -----------------------------------------------------
  typedef struct {
    bit start, pause, stop;
    int per, maxs, n;
    logic [1:0] st;
    bit en, sp;
    int cnt;
  } vec_t;

  vec_t vecs[21];
  int   hold[3];

  initial begin
    vecs[0]  = '{0, 0, 0, 3, 0, 20, 2'b00, 0, 0, 0};   // idle after reset
    vecs[1]  = '{1, 0, 0, 3, 0, 7,  2'b00, 0, 0, 0};   // press still in flight
    vecs[2]  = '{1, 0, 0, 3, 0, 1,  2'b01, 1, 0, 0};   // RUN at edge 7
    vecs[3]  = '{1, 0, 0, 3, 0, 3,  2'b01, 1, 1, 1};   // step at 10
    vecs[4]  = '{0, 0, 0, 3, 0, 3,  2'b01, 1, 1, 2};   // step at 13
    vecs[5]  = '{0, 0, 0, 3, 0, 2,  2'b01, 1, 0, 2};
    vecs[6]  = '{0, 0, 1, 3, 0, 3,  2'b01, 1, 0, 3};   // 3-cycle stop glitch
    vecs[7]  = '{0, 0, 0, 3, 0, 1,  2'b01, 1, 1, 4};   // cadence unbroken, step at 19
    vecs[8]  = '{0, 1, 0, 3, 0, 7,  2'b01, 1, 0, 6};
    vecs[9]  = '{0, 1, 0, 3, 0, 1,  2'b10, 1, 0, 6};   // PAUSE at 27
    vecs[10] = '{0, 0, 0, 3, 0, 50, 2'b10, 1, 0, 6};   // silent, held
    vecs[11] = '{1, 0, 0, 3, 0, 8,  2'b01, 1, 0, 6};   // resume at 85
    vecs[12] = '{1, 0, 0, 3, 0, 2,  2'b01, 1, 1, 7};   // preserved phase: step at 87
    vecs[13] = '{0, 0, 0, 3, 0, 3,  2'b01, 1, 1, 8};
    vecs[14] = '{1, 0, 1, 3, 0, 7,  2'b01, 1, 0, 10};
    vecs[15] = '{1, 0, 1, 3, 0, 1,  2'b00, 0, 0, 10};  // start+stop together -> IDLE
    vecs[16] = '{0, 0, 0, 3, 0, 20, 2'b00, 0, 0, 10};  // count readable in IDLE
    vecs[17] = '{1, 0, 0, 2, 3, 8,  2'b01, 1, 0, 0};   // restart clears count
    vecs[18] = '{1, 0, 0, 2, 3, 2,  2'b01, 1, 1, 1};
    vecs[19] = '{1, 0, 0, 2, 3, 4,  2'b11, 0, 1, 3};   // final step with DONE
    vecs[20] = '{0, 0, 0, 2, 3, 10, 2'b11, 0, 0, 3};

    model_clear();
    reset = 1'b1; start_btn = 0; pause_btn = 0; stop_btn = 0;
    period = PW'(3); max_steps = 8'd0;
    tick();
    tick();
    check("reset", 2'b00, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      start_btn = vecs[i].start;
      pause_btn = vecs[i].pause;
      stop_btn  = vecs[i].stop;
      period    = PW'(vecs[i].per);
      max_steps = 8'(vecs[i].maxs);
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].sp, 8'(vecs[i].cnt));
    end

    // Restart from DONE with period 0: step every RUN cycle
    start_btn = 1; period = '0; max_steps = 8'd0;
    repeat (8) tick();
    check("done_restart", 2'b01, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("per0_step%0d", i), 2'b01, 1'b1, 1'b1, 8'(i));
    end

    // Reset while a compare is due every cycle
    reset = 1'b1; start_btn = 0;
    tick();
    check("reset_mid_run", 2'b00, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("post_reset_idle", 2'b00, 1'b0, 1'b0, 8'd0);

    // Random phase against the model
    for (int b = 0; b < 3; b++) hold[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] > 0) hold[b]--;
        else if ($urandom_range(0, 39) == 0)
          hold[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 15);
      end
      start_btn = hold[0] > 0;
      pause_btn = hold[1] > 0;
      stop_btn  = hold[2] > 0;
      reset     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0)  period    = PW'($urandom_range(0, 5));
      if ($urandom_range(0, 199) == 0) max_steps = 8'($urandom_range(0, 6));
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
